// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the Wishbone LCD init master.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StInit,
        StIdle,
        StReq,
        StWait,
        StDly
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LINE2_OFS     = 8'h40;

    localparam logic [2:0] INIT_LEN = 3'd5;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = CMD_FUNC_SET;
            3'd1:    cmd = CMD_FUNC_SET;
            3'd2:    cmd = CMD_DISP_ON;
            3'd3:    cmd = CMD_CLEAR;
            3'd4:    cmd = CMD_ENTRY;
            default: cmd = CMD_FUNC_SET;
        endcase
        return cmd;
    endfunction

    // Clear and home need the long post-command delay.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lcd_delay_timer #(
    parameter int unsigned RESET_LOAD = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic        o_done
);

    logic [31:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= 32'(RESET_LOAD);
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    assign o_done = (cnt_q == 32'd0);

endmodule

// File: rtl/wb_lcd_init_master.sv
// Wishbone master that initialises an HD44780 LCD slave and then streams bytes to it,
// tracking the cursor and inserting line-change commands.
module wb_lcd_init_master
    import lcd_pkg::*;
#(
    parameter logic [29:0] LCD_BASE      = 30'h0,
    parameter int unsigned POWERUP_DELAY = 1000,
    parameter int unsigned CMD_DELAY     = 100,
    parameter int unsigned CLEAR_DELAY   = 2000,
    parameter int unsigned ACK_TIMEOUT   = 255,
    parameter int unsigned COLS          = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_is_cmd,
    output logic        o_byte_ready,
    output logic        o_init_done,
    output logic        o_err
);

    localparam logic [4:0] COLS_W = 5'(COLS);

    lcd_state_e  state_q, state_d;
    logic [2:0]  rom_idx_q, rom_idx_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  col_q, col_d;
    logic        line_q, line_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic [31:0] to_q, to_d;
    logic [31:0] to_inc;

    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_done;
    logic        wrap;
    logic        unused_rdata;

    assign unused_rdata = ^i_wb_data;

    lcd_delay_timer #(
        .RESET_LOAD (POWERUP_DELAY)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_done     (tmr_done)
    );

    // A char arriving at the end of a line first triggers a set-address command.
    assign wrap   = i_byte_valid && !i_byte_is_cmd && (col_q == COLS_W);
    assign to_inc = to_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        rom_idx_d   = rom_idx_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rs_d        = rs_q;
        data_d      = data_q;
        col_d       = col_q;
        line_d      = line_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        to_d        = to_q;
        tmr_load    = 1'b0;
        tmr_val     = is_long_cmd(rs_q, data_q) ? 32'(CLEAR_DELAY) : 32'(CMD_DELAY);

        unique case (state_q)
            StPwrup: begin
                if (tmr_done) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                if (rom_idx_q == INIT_LEN) begin
                    init_done_d = 1'b1;
                    col_d       = 5'd0;
                    line_d      = 1'b0;
                    state_d     = StIdle;
                end else begin
                    data_d    = init_rom(rom_idx_q);
                    rs_d      = 1'b0;
                    rom_idx_d = rom_idx_q + 3'd1;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = StReq;
                end
            end
            StIdle: begin
                if (i_byte_valid) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = StReq;
                    if (wrap) begin
                        data_d = CMD_SET_DDRAM | (line_q ? 8'h00 : LINE2_OFS);
                        rs_d   = 1'b0;
                        line_d = !line_q;
                        col_d  = 5'd0;
                    end else begin
                        data_d = i_byte_data;
                        rs_d   = !i_byte_is_cmd;
                        if (!i_byte_is_cmd) begin
                            col_d = col_q + 5'd1;
                        end else if (is_long_cmd(1'b0, i_byte_data)) begin
                            col_d  = 5'd0;
                            line_d = 1'b0;
                        end else if (i_byte_data[7]) begin
                            line_d = i_byte_data[6];
                            col_d  = {1'b0, i_byte_data[3:0]};
                        end
                    end
                end
            end
            StReq: begin
                if (i_wb_ack) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = StDly;
                end else if (!i_wb_stall) begin
                    stb_d   = 1'b0;
                    to_d    = 32'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                to_d = to_inc;
                if (i_wb_ack) begin
                    cyc_d    = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = StDly;
                end else if (to_inc >= 32'(ACK_TIMEOUT)) begin
                    cyc_d    = 1'b0;
                    err_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = StDly;
                end
            end
            StDly: begin
                if (tmr_done) begin
                    state_d = init_done_q ? StIdle : StInit;
                end
            end
            default: begin
                state_d = StPwrup;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StPwrup;
            rom_idx_q   <= 3'd0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            col_q       <= 5'd0;
            line_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            to_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            rom_idx_q   <= rom_idx_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            col_q       <= col_d;
            line_q      <= line_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            to_q        <= to_d;
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = 1'b1;
    assign o_wb_addr    = {LCD_BASE[29:1], rs_q};
    assign o_wb_data    = {24'h0, data_q};
    assign o_wb_sel     = 4'b0001;
    assign o_byte_ready = (state_q == StIdle) && !wrap;
    assign o_init_done  = init_done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_wb_lcd_init_master.sv
// Directed bench for wb_lcd_init_master with a simple Wishbone slave model.
module tb_wb_lcd_init_master;

    localparam logic [29:0] BASE  = 30'h0000_1234;
    localparam int unsigned PWRUP = 20;
    localparam int unsigned CMDD  = 8;
    localparam int unsigned CLRD  = 30;
    localparam int unsigned ATO   = 12;
    localparam int unsigned NCOLS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        wb_ack;
    logic        wb_stall;
    logic        bvalid;
    logic [7:0]  bdata;
    logic        bcmd;
    logic        bready;
    logic        init_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model configuration and logs
    int          stall_cfg = 0;
    logic        never_ack = 1'b0;
    int          stall_cnt = 0;
    int          stall_seen = 0;
    int          cyc_n = 0;
    int          ack_at = 0;
    int          n_acks = 0;
    logic [7:0]  log_data[$];
    logic [29:0] log_addr[$];
    int          log_gap[$];
    int          log_stall[$];

    always #5 clk = ~clk;

    wb_lcd_init_master #(
        .LCD_BASE      (BASE),
        .POWERUP_DELAY (PWRUP),
        .CMD_DELAY     (CMDD),
        .CLEAR_DELAY   (CLRD),
        .ACK_TIMEOUT   (ATO),
        .COLS          (NCOLS)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .o_wb_cyc      (cyc),
        .o_wb_stb      (stb),
        .o_wb_we       (we),
        .o_wb_addr     (addr),
        .o_wb_data     (wdata),
        .o_wb_sel      (sel),
        .i_wb_ack      (wb_ack),
        .i_wb_stall    (wb_stall),
        .i_wb_data     (32'h0),
        .i_byte_valid  (bvalid),
        .i_byte_data   (bdata),
        .i_byte_is_cmd (bcmd),
        .o_byte_ready  (bready),
        .o_init_done   (init_done),
        .o_err         (err)
    );

    assign wb_stall = stb && (stall_cnt < stall_cfg);

    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        if (wb_ack && cyc) begin
            ack_at = cyc_n;
            n_acks = n_acks + 1;
        end
        if (stb && wb_stall) stall_seen = stall_seen + 1;
        if (cyc && stb && !wb_stall) begin
            log_data.push_back(wdata[7:0]);
            log_addr.push_back(addr);
            log_gap.push_back(cyc_n - ack_at);
            log_stall.push_back(stall_seen);
            stall_seen = 0;
        end
        wb_ack <= cyc && stb && !wb_stall && !never_ack && !rst;
        if (stb && wb_stall) stall_cnt <= stall_cnt + 1;
        else if (!stb) stall_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_addr.delete();
        log_gap.delete();
        log_stall.delete();
        n_acks = 0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 3000 && !init_done; i++) tick();
        check("init_done_reached", {31'h0, init_done}, 32'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && !(bready && !cyc); i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic is_cmd);
        int i;
        bvalid = 1'b1;
        bdata  = b;
        bcmd   = is_cmd;
        for (i = 0; i < 600 && !bready; i++) tick();
        if (!bready) check("send_accept", {31'h0, bready}, 32'h1);
        tick();
        bvalid = 1'b0;
    endtask

    logic [7:0] init_exp[5];
    logic [29:0] addr_cmd;
    logic [29:0] addr_chr;
    int cnt;

    initial begin
        init_exp = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        addr_cmd = {BASE[29:1], 1'b0};
        addr_chr = {BASE[29:1], 1'b1};
        rst    = 1'b1;
        bvalid = 1'b0;
        bdata  = 8'h00;
        bcmd   = 1'b0;
        wb_ack = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cyc", {31'h0, cyc}, 32'h0);
        check("rst_stb", {31'h0, stb}, 32'h0);
        check("rst_we", {31'h0, we}, 32'h1);
        check("rst_sel", {28'h0, sel}, 32'h1);
        check("rst_addr", {2'b0, addr}, {2'b0, addr_cmd});
        check("rst_data", wdata, 32'h0);
        check("rst_ready", {31'h0, bready}, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        clear_log();
        rst = 1'b0;
        tick();
        check("pwrup_ready", {31'h0, bready}, 32'h0);

        // Init sequence
        wait_init();
        check("init_writes", log_data.size(), 5);
        for (int i = 0; i < 5 && i < log_data.size(); i++) begin
            check($sformatf("init_data%0d", i), {24'h0, log_data[i]}, {24'h0, init_exp[i]});
            check($sformatf("init_addr%0d", i), {2'b0, log_addr[i]}, {2'b0, addr_cmd});
        end
        for (int i = 1; i < 5 && i < log_gap.size(); i++) begin
            check($sformatf("init_gap%0d", i),
                  {31'h0, (log_gap[i] >= ((i == 4) ? int'(CLRD) : int'(CMDD)))}, 32'h1);
        end
        check("idle_ready", {31'h0, bready}, 32'h1);

        // 17 chars: line wrap inserts 0xC0 before 'Q'
        clear_log();
        for (int i = 0; i < 17; i++) send_byte(8'h41 + 8'(i), 1'b0);
        for (int i = 0; i < 500 && log_data.size() < 18; i++) tick();
        wait_idle();
        check("wrap_writes", log_data.size(), 18);
        for (int i = 0; i < 16 && i < log_data.size(); i++) begin
            check($sformatf("char%0d", i), {24'h0, log_data[i]}, 32'h41 + i);
            check($sformatf("char_rs%0d", i), {2'b0, log_addr[i]}, {2'b0, addr_chr});
        end
        if (log_data.size() >= 18) begin
            check("wrap_cmd", {24'h0, log_data[16]}, 32'hC0);
            check("wrap_cmd_rs", {2'b0, log_addr[16]}, {2'b0, addr_cmd});
            check("wrap_char", {24'h0, log_data[17]}, 32'h51);
            check("wrap_char_rs", {2'b0, log_addr[17]}, {2'b0, addr_chr});
        end

        // Stall for 3 cycles
        clear_log();
        stall_cfg = 3;
        send_byte(8'h5A, 1'b0);
        wait_idle();
        stall_cfg = 0;
        check("stall_writes", log_data.size(), 1);
        check("stall_acks", n_acks, 1);
        if (log_data.size() >= 1) begin
            check("stall_cycles", log_stall[0], 3);
            check("stall_data", {24'h0, log_data[0]}, 32'h5A);
        end

        // Ack timeout
        clear_log();
        check("pre_timeout_err", {31'h0, err}, 32'h0);
        never_ack = 1'b1;
        send_byte(8'h78, 1'b0);
        cnt = 0;
        while (cyc && cnt < 100) begin
            cnt++;
            tick();
        end
        check("timeout_cyc_len", {31'h0, (cnt >= int'(ATO) && cnt <= int'(ATO) + 2)}, 32'h1);
        check("timeout_err", {31'h0, err}, 32'h1);
        never_ack = 1'b0;
        wait_idle();
        send_byte(8'h79, 1'b0);
        wait_idle();
        check("after_timeout_writes", log_data.size(), 2);
        if (log_data.size() >= 2) check("after_timeout_data", {24'h0, log_data[1]}, 32'h79);
        check("err_sticky", {31'h0, err}, 32'h1);

        // Reset during WAIT
        never_ack = 1'b1;
        send_byte(8'h72, 1'b0);
        for (int i = 0; i < 20 && !(cyc && !stb); i++) tick();
        check("in_wait", {30'h0, cyc, stb}, 32'h2);
        rst = 1'b1;
        tick();
        check("wait_rst_cyc", {31'h0, cyc}, 32'h0);
        check("wait_rst_err", {31'h0, err}, 32'h0);
        check("wait_rst_init", {31'h0, init_done}, 32'h0);
        never_ack = 1'b0;
        clear_log();
        rst = 1'b0;
        wait_init();
        check("reinit_writes", log_data.size(), 5);
        if (log_data.size() >= 1) check("reinit_first", {24'h0, log_data[0]}, 32'h38);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
